// File: rtl/neurocore_lif.sv
// Single leaky-integrate-and-fire neuron: shift-based leak on accepted samples,
// threshold fire with a one-cycle spike pulse, then a configurable refractory hold-off.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_INTEGRATE | accepting samples, in_ready high
// ST_REFRACT   | post-spike hold-off, refrac_cnt_q counts down to 1, in_ready low
module neurocore_lif #(
    parameter int WIDTH       = 8,
    parameter int THRESH_INIT = 100,
    parameter int LEAK_INIT   = 2,
    parameter int REFRAC_INIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_current,
    output logic             in_ready,
    output logic             spike,
    output logic [WIDTH-1:0] membrane,
    output logic             refractory,
    output logic [WIDTH-1:0] spike_count
);

    localparam logic [WIDTH-1:0] THR_RST    = THRESH_INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LEAK_RST   = LEAK_INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] REFRAC_RST = REFRAC_INIT[WIDTH-1:0];

    typedef enum logic {
        ST_INTEGRATE = 1'b0,
        ST_REFRACT   = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] v_q;
    logic [WIDTH-1:0] thr_q;
    logic [WIDTH-1:0] leak_q;
    logic [WIDTH-1:0] refrac_q;
    logic [WIDTH-1:0] refrac_cnt_q;
    logic [WIDTH-1:0] spike_count_q;
    logic             spike_q;
    logic             in_ready_q;
    logic             refractory_q;

    logic [WIDTH-1:0] leak_amt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] v_d;
    logic             fire;
    logic             accept;

    assign accept = in_valid && in_ready_q;

    // Leak amount never exceeds V, so the subtraction cannot underflow; only the
    // add can overflow, which the extra bit catches for saturation.
    always_comb begin
        leak_amt = '0;
        if (leak_q != '0 && 32'(leak_q) < WIDTH) begin
            leak_amt = v_q >> leak_q;
        end
        sum  = {1'b0, v_q} - {1'b0, leak_amt} + {1'b0, in_current};
        v_d  = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        fire = (v_d >= thr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INTEGRATE;
            v_q           <= '0;
            thr_q         <= THR_RST;
            leak_q        <= LEAK_RST;
            refrac_q      <= REFRAC_RST;
            refrac_cnt_q  <= '0;
            spike_count_q <= '0;
            spike_q       <= 1'b0;
            in_ready_q    <= 1'b1;
            refractory_q  <= 1'b0;
        end else begin
            spike_q <= 1'b0;

            if (cfg_we) begin
                case (cfg_addr)
                    2'd0:    thr_q    <= cfg_data;
                    2'd1:    leak_q   <= cfg_data;
                    2'd2:    refrac_q <= cfg_data;
                    default: ;
                endcase
            end

            case (state_q)
                ST_INTEGRATE: begin
                    if (accept) begin
                        if (fire) begin
                            v_q           <= '0;
                            spike_q       <= 1'b1;
                            spike_count_q <= spike_count_q + 1'b1;
                            if (refrac_q != '0) begin
                                state_q      <= ST_REFRACT;
                                refrac_cnt_q <= refrac_q;
                                in_ready_q   <= 1'b0;
                                refractory_q <= 1'b1;
                            end
                        end else begin
                            v_q <= v_d;
                        end
                    end
                end
                ST_REFRACT: begin
                    refrac_cnt_q <= refrac_cnt_q - 1'b1;
                    if (refrac_cnt_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                        state_q      <= ST_INTEGRATE;
                        in_ready_q   <= 1'b1;
                        refractory_q <= 1'b0;
                    end
                end
                default: state_q <= ST_INTEGRATE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign spike       = spike_q;
    assign membrane    = v_q;
    assign refractory  = refractory_q;
    assign spike_count = spike_count_q;

endmodule

// File: tb/tb_neurocore_lif.sv
// Scoreboard bench for neurocore_lif: a behavioural neuron model pushes the expected
// outputs for each driven cycle, which are popped and compared after the clock edge.
module tb_neurocore_lif;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_data = 8'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_current = 8'd0;
    logic       in_ready;
    logic       spike;
    logic [7:0] membrane;
    logic       refractory;
    logic [7:0] spike_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int spk;
        int mem;
        int rdy;
        int refr;
        int cnt;
    } exp_t;

    exp_t sb[$];

    // Model state
    int m_v, m_thr, m_leak, m_r, m_block, m_count, m_spike;

    neurocore_lif #(
        .WIDTH(8), .THRESH_INIT(100), .LEAK_INIT(2), .REFRAC_INIT(3)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_current(in_current), .in_ready(in_ready),
        .spike(spike), .membrane(membrane), .refractory(refractory),
        .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        n_vec++;
        if (obs != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Drive one cycle, advance the model, then compare against the popped expectation.
    task automatic cyc(input bit r, input bit v, input int cur,
                       input bit we = 1'b0, input int a = 0, input int d = 0);
        exp_t e;
        int   lk, n;
        bit   rdy;
        @(negedge clk);
        rst = r; in_valid = v; in_current = cur[7:0];
        cfg_we = we; cfg_addr = a[1:0]; cfg_data = d[7:0];
        if (r) begin
            m_v = 0; m_thr = 100; m_leak = 2; m_r = 3;
            m_block = 0; m_count = 0; m_spike = 0;
        end else begin
            rdy = (m_block == 0);
            m_spike = 0;
            if (m_block > 0) m_block--;
            if (v && rdy) begin
                lk = (m_leak == 0 || m_leak >= 8) ? 0 : (m_v >> m_leak);
                n  = m_v - lk + cur;
                if (n > 255) n = 255;
                if (n >= m_thr) begin
                    m_v = 0;
                    m_spike = 1;
                    m_count = (m_count + 1) % 256;
                    m_block = m_r;
                end else begin
                    m_v = n;
                end
            end
            if (we) begin
                case (a)
                    0: m_thr  = d;
                    1: m_leak = d;
                    2: m_r    = d;
                    default: ;
                endcase
            end
        end
        e.spk = m_spike; e.mem = m_v; e.rdy = (m_block == 0) ? 1 : 0;
        e.refr = (m_block == 0) ? 0 : 1; e.cnt = m_count;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("spike", int'(spike), e.spk);
        chk("membrane", int'(membrane), e.mem);
        chk("in_ready", int'(in_ready), e.rdy);
        chk("refractory", int'(refractory), e.refr);
        chk("spike_count", int'(spike_count), e.cnt);
    endtask

    initial begin
        // reset
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_mem", int'(membrane), 0);
        chk("rst_refr", int'(refractory), 0);

        // defaults thr=100 leak=2, R=0
        cyc(0, 0, 0, 1, 2, 0);
        cyc(0, 1, 40); chk("t1_m40", int'(membrane), 40);
        cyc(0, 1, 40); chk("t1_m70", int'(membrane), 70);
        cyc(0, 1, 40); chk("t1_m93", int'(membrane), 93);
        cyc(0, 1, 40); chk("t1_spk", int'(spike), 1);
        chk("t1_m0", int'(membrane), 0); chk("t1_cnt", int'(spike_count), 1);
        chk("t1_rdy", int'(in_ready), 1);
        cyc(0, 0, 0); chk("t1_spk_off", int'(spike), 0);

        // leak off, thr=255, saturation
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0, 255);
        cyc(0, 1, 200); chk("t2_m200", int'(membrane), 200);
        cyc(0, 1, 200); chk("t2_spk", int'(spike), 1);
        chk("t2_cnt", int'(spike_count), 2);

        // R=3, thr=10, held sample across refractory gap
        cyc(0, 0, 0, 1, 2, 3);
        cyc(0, 0, 0, 1, 0, 10);
        cyc(0, 1, 20); chk("t3_spk", int'(spike), 1);
        chk("t3_rdy_n1", int'(in_ready), 0); chk("t3_refr_n1", int'(refractory), 1);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1, 20); chk("t3_rdy_gap", int'(in_ready), 0);
        end
        cyc(0, 1, 20); chk("t3_rdy_n4", int'(in_ready), 1);
        chk("t3_cnt_hold", int'(spike_count), 3);
        cyc(0, 1, 20); chk("t3_cnt_n5", int'(spike_count), 4);
        cyc(0, 0, 0, 1, 1, 2);
        cyc(0, 0, 0, 1, 0, 100);
        cyc(0, 0, 0, 1, 2, 0);
        cyc(0, 0, 0);
        chk("t3_back", int'(in_ready), 1);

        // same-cycle config write uses old threshold
        cyc(0, 1, 6, 1, 0, 5); chk("t4_nospk", int'(spike), 0);
        chk("t4_m6", int'(membrane), 6);
        cyc(0, 1, 0); chk("t4_spk", int'(spike), 1);

        // reset in the middle of a refractory period
        cyc(0, 0, 0, 1, 0, 0);
        while (m_count < 6) cyc(0, 1, 0);
        cyc(0, 0, 0, 1, 2, 3);
        cyc(0, 1, 0); chk("t5_cnt7", int'(spike_count), 7);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("t5_rdy", int'(in_ready), 1); chk("t5_refr", int'(refractory), 0);
        chk("t5_cnt", int'(spike_count), 0); chk("t5_mem", int'(membrane), 0);
        cyc(0, 1, 99); chk("t5_thr100", int'(spike), 0);

        // 256 spikes at thr=0, counter wraps
        cyc(0, 0, 0, 1, 2, 0);
        cyc(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 256; k++) begin
            cyc(0, 1, 0);
            if (k == 0) chk("t6_spk_first", int'(spike), 1);
            cyc(0, 0, 0);
        end
        chk("t6_wrap", int'(spike_count), 0);

        // random traffic with random configuration
        for (int k = 0; k < 400; k++) begin
            int a, d;
            a = $urandom_range(0, 3);
            case (a)
                0: d = $urandom_range(0, 255);
                1: d = $urandom_range(0, 9);
                2: d = $urandom_range(0, 4);
                default: d = $urandom_range(0, 255);
            endcase
            cyc(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 255),
                ($urandom_range(0, 7) == 0), a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
